// File: rtl/argmax_classifier_pkg.sv
// -----------------------------------------------------------------------------
// argmax_classifier_pkg
//
// Shared definitions for the network output stage:
//   - argmax_state_t     : IDLE / SCAN / PUBLISH controller states
//   - ARGMAX_CMP_W       : width the compare helper works at (element widths
//                          up to this value are supported)
//   - argmax_index_width : class-index width for a vector length, minimum 1
//   - argmax_beats       : signed "strictly greater" step used to update a
//                          running maximum; kept here so a top-k reducer can
//                          reuse the same ordering rule
// -----------------------------------------------------------------------------
package argmax_classifier_pkg;

    typedef enum logic [1:0] {
        ARGMAX_IDLE    = 2'd0,
        ARGMAX_SCAN    = 2'd1,
        ARGMAX_PUBLISH = 2'd2
    } argmax_state_t;

    localparam int ARGMAX_CMP_W = 64;

    function automatic int argmax_index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Strictly greater: a candidate equal to the incumbent never wins, so a
    // running maximum keeps the lowest index among equal values.
    function automatic logic argmax_beats(
        input logic signed [ARGMAX_CMP_W-1:0] cand,
        input logic signed [ARGMAX_CMP_W-1:0] incumbent
    );
        return cand > incumbent;
    endfunction

endpackage

// File: rtl/argmax_classifier.sv
// -----------------------------------------------------------------------------
// argmax_classifier
//
// Output stage of the network: captures the signed score vector on an
// inputs_ready pulse, scans it one element per cycle and publishes the index
// and value of the maximum. Latency from the capturing edge to outputs_ready
// is NUM_INPUTS cycles; a new vector is accepted during the outputs_ready
// cycle.
//
// Parameters:
//   DATA_WIDTH  - width of each signed element (<= ARGMAX_CMP_W)
//   NUM_INPUTS  - vector length / number of classes (>= 1)
//   INDEX_WIDTH - class index width, $clog2(NUM_INPUTS) with a minimum of 1
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   inputs_ready  in   one-cycle pulse, inputs valid
//   inputs        in   NUM_INPUTS x DATA_WIDTH two's-complement scores
//   class_index   out  index of the maximum (lowest index on ties)
//   max_value     out  value of the maximum
//   margin        out  max minus second-highest, unsigned DATA_WIDTH+1
//   outputs_ready out  one-cycle pulse, result registers just updated
//   busy          out  high while a vector is being processed
//   overrun       out  sticky, inputs_ready arrived while busy (dropped)
//
// Build option:
//   ARGMAX_MARGIN_EN - when defined, the scan also tracks the second-highest
//                      value and margin reports max - second. When undefined
//                      that logic is absent and margin is tied to 0.
// -----------------------------------------------------------------------------
module argmax_classifier
    import argmax_classifier_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_INPUTS  = 10,
    parameter int INDEX_WIDTH = argmax_index_width(NUM_INPUTS)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  inputs_ready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputs,
    output logic [INDEX_WIDTH-1:0]                class_index,
    output logic [DATA_WIDTH-1:0]                 max_value,
    output logic [DATA_WIDTH:0]                   margin,
    output logic                                  outputs_ready,
    output logic                                  busy,
    output logic                                  overrun
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

    // Sign-extend an element to the width the shared compare helper uses.
    function automatic logic signed [ARGMAX_CMP_W-1:0] widen(input logic [DATA_WIDTH-1:0] v);
        return ARGMAX_CMP_W'(signed'(v));
    endfunction

    argmax_state_t          state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  max_q, max_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [INDEX_WIDTH-1:0] class_index_q, class_index_d;
    logic [DATA_WIDTH-1:0]  max_value_q, max_value_d;
    logic                   outputs_ready_q, outputs_ready_d;
    logic                   overrun_q, overrun_d;
    logic                   load_en;
    logic [DATA_WIDTH-1:0]  elem;
    logic [DATA_WIDTH-1:0]  data_q [NUM_INPUTS];

`ifdef ARGMAX_MARGIN_EN
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] second_q, second_d;
    logic [DATA_WIDTH:0]   margin_q, margin_d;
    logic [DATA_WIDTH:0]   margin_calc;

    // max >= second always holds, so the DATA_WIDTH+1 difference of the
    // sign-extended operands is non-negative and never wraps. A single-element
    // vector has no runner-up; report 0 rather than distance to the seed.
    assign margin_calc = (NUM_INPUTS == 1) ? '0
                       : (DATA_WIDTH+1)'(signed'(max_q)) - (DATA_WIDTH+1)'(signed'(second_q));
`endif

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        max_d           = max_q;
        idx_d           = idx_q;
        class_index_d   = class_index_q;
        max_value_d     = max_value_q;
        outputs_ready_d = 1'b0;
        overrun_d       = overrun_q | (inputs_ready & (state_q != ARGMAX_IDLE));
        load_en         = 1'b0;
        elem            = data_q[cnt_q];
`ifdef ARGMAX_MARGIN_EN
        second_d        = second_q;
        margin_d        = margin_q;
`endif

        case (state_q)
            ARGMAX_IDLE: begin
                if (inputs_ready) begin
                    // Seed straight from the port: element 0 is already the
                    // running max, so the scan starts at element 1.
                    load_en = 1'b1;
                    max_d   = inputs[0];
                    idx_d   = '0;
                    cnt_d   = INDEX_WIDTH'(1);
`ifdef ARGMAX_MARGIN_EN
                    second_d = MOST_NEG;
`endif
                    state_d = (NUM_INPUTS == 1) ? ARGMAX_PUBLISH : ARGMAX_SCAN;
                end
            end

            ARGMAX_SCAN: begin
                if (argmax_beats(widen(elem), widen(max_q))) begin
                    max_d = elem;
                    idx_d = cnt_q;
`ifdef ARGMAX_MARGIN_EN
                    second_d = max_q;  // demoted max becomes the runner-up
`endif
                end
`ifdef ARGMAX_MARGIN_EN
                // Not above the max but above the runner-up; an element equal
                // to the max lands here too, which drives margin to 0 on ties.
                else if (argmax_beats(widen(elem), widen(second_q))) begin
                    second_d = elem;
                end
`endif
                cnt_d = cnt_q + INDEX_WIDTH'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ARGMAX_PUBLISH;
                end
            end

            ARGMAX_PUBLISH: begin
                class_index_d   = idx_q;
                max_value_d     = max_q;
`ifdef ARGMAX_MARGIN_EN
                margin_d        = margin_calc;
`endif
                outputs_ready_d = 1'b1;
                state_d         = ARGMAX_IDLE;
            end

            default: state_d = ARGMAX_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking assignments here would chain updates in order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ARGMAX_IDLE;
            cnt_q           <= '0;
            max_q           <= '0;
            idx_q           <= '0;
            class_index_q   <= '0;
            max_value_q     <= '0;
            outputs_ready_q <= 1'b0;
            overrun_q       <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            second_q        <= '0;
            margin_q        <= '0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            max_q           <= max_d;
            idx_q           <= idx_d;
            class_index_q   <= class_index_d;
            max_value_q     <= max_value_d;
            outputs_ready_q <= outputs_ready_d;
            overrun_q       <= overrun_d;
`ifdef ARGMAX_MARGIN_EN
            second_q        <= second_d;
            margin_q        <= margin_d;
`endif
        end
    end

    // NOTE: the score buffer is deliberately cleared on reset so no stale
    // vector survives it; this costs a reset on each flop and keeps the buffer
    // out of RAM inference.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                data_q[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                data_q[i] <= inputs[i];
            end
        end
    end

    assign class_index   = class_index_q;
    assign max_value     = max_value_q;
    assign outputs_ready = outputs_ready_q;
    assign busy          = (state_q != ARGMAX_IDLE);
    assign overrun       = overrun_q;
`ifdef ARGMAX_MARGIN_EN
    assign margin        = margin_q;
`else
    assign margin        = '0;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// -----------------------------------------------------------------------------
// tb_argmax_classifier
//
// Bench for argmax_classifier: a 10-class instance (main) and a 1-class
// instance share clock and reset. Expected results come from a whole-vector
// reference model (argmax over the array, runner-up over the remaining
// elements). Stimulus is driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_argmax_classifier;

    localparam int DW = 32;
    localparam int N  = 10;
    localparam int IW = 4;

    typedef logic signed [DW-1:0] vec_t [N];

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    always #5 clock = ~clock;

    logic                 inputs_ready = 1'b0;
    logic [N-1:0][DW-1:0] inputs = '0;
    logic [IW-1:0]        class_index;
    logic [DW-1:0]        max_value;
    logic [DW:0]          margin;
    logic                 outputs_ready, busy, overrun;

    logic                 s_inputs_ready = 1'b0;
    logic [0:0][DW-1:0]   s_inputs = '0;
    logic [0:0]           s_class_index;
    logic [DW-1:0]        s_max_value;
    logic [DW:0]          s_margin;
    logic                 s_outputs_ready, s_busy, s_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    argmax_classifier #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
        .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(inputs),
        .class_index(class_index), .max_value(max_value), .margin(margin),
        .outputs_ready(outputs_ready), .busy(busy), .overrun(overrun)
    );

    argmax_classifier #(.DATA_WIDTH(DW), .NUM_INPUTS(1)) dut_single (
        .clock(clock), .reset(reset), .inputs_ready(s_inputs_ready), .inputs(s_inputs),
        .class_index(s_class_index), .max_value(s_max_value), .margin(s_margin),
        .outputs_ready(s_outputs_ready), .busy(s_busy), .overrun(s_overrun)
    );

    // Reference: first index holding the largest value; runner-up is the
    // largest of all other elements; margin only exists with the option.
    function automatic void model(input vec_t v, output int e_idx, output longint e_max,
                                  output longint e_mg);
        longint sec;
        e_idx = 0;
        for (int i = 1; i < N; i++)
            if (longint'(v[i]) > longint'(v[e_idx])) e_idx = i;
        e_max = longint'(v[e_idx]);
        sec = -(longint'(1) << 40);
        for (int j = 0; j < N; j++)
            if (j != e_idx && longint'(v[j]) > sec) sec = longint'(v[j]);
`ifdef ARGMAX_MARGIN_EN
        e_mg = e_max - sec;
`else
        e_mg = sec - sec;
`endif
    endfunction

    // Called at a falling edge: presents the vector for one clock, then counts
    // edges until outputs_ready. lat = -1 when it never shows up.
    task automatic launch(input vec_t v, output int lat);
        for (int i = 0; i < N; i++) inputs[i] = v[i];
        inputs_ready = 1'b1;
        @(negedge clock);
        inputs_ready = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (lat < 0) begin
                @(negedge clock);
                if (outputs_ready) lat = k;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if ({class_index, max_value, margin} !== '0) $display("FAIL reset_outputs: got %h expected 0", {class_index, max_value, margin}); else n_pass++;
        n_checks++; if ({outputs_ready, busy, overrun} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {outputs_ready, busy, overrun}); else n_pass++;
        n_checks++; if ({s_outputs_ready, s_busy, s_overrun} !== 3'b000) $display("FAIL reset_single_flags: got %b expected 000", {s_outputs_ready, s_busy, s_overrun}); else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_distinct();
        vec_t v = '{3, -5, 7, 100, 2, 0, -1, 99, 4, 6};
        int lat, e_idx; longint e_max, e_mg;
        model(v, e_idx, e_max, e_mg);
        launch(v, lat);
        n_checks++; if (lat !== 10) $display("FAIL distinct_latency: got %0d expected 10", lat); else n_pass++;
        n_checks++; if (class_index !== IW'(e_idx)) $display("FAIL distinct_index: got %0d expected %0d", class_index, e_idx); else n_pass++;
        n_checks++; if (max_value !== DW'(e_max)) $display("FAIL distinct_value: got %0d expected %0d", $signed(max_value), e_max); else n_pass++;
        n_checks++; if (margin !== (DW+1)'(e_mg)) $display("FAIL distinct_margin: got %0d expected %0d", margin, e_mg); else n_pass++;
        @(negedge clock);
        n_checks++; if (outputs_ready !== 1'b0) $display("FAIL distinct_pulse_width: got %b expected 0", outputs_ready); else n_pass++;
        n_checks++; if (class_index !== IW'(3)) $display("FAIL distinct_hold: got %0d expected 3", class_index); else n_pass++;
    endtask

    task automatic test_negative_tie();
        vec_t v = '{-8, -2, -9, -2, -30, -5, -7, -4, -3, -6};
        int lat, e_idx; longint e_max, e_mg;
        model(v, e_idx, e_max, e_mg);
        launch(v, lat);
        n_checks++; if (lat !== 10) $display("FAIL tie_latency: got %0d expected 10", lat); else n_pass++;
        n_checks++; if (class_index !== IW'(e_idx)) $display("FAIL tie_index: got %0d expected %0d", class_index, e_idx); else n_pass++;
        n_checks++; if (max_value !== DW'(e_max)) $display("FAIL tie_value: got %0d expected %0d", $signed(max_value), e_max); else n_pass++;
        n_checks++; if (margin !== (DW+1)'(e_mg)) $display("FAIL tie_margin: got %0d expected %0d", margin, e_mg); else n_pass++;
    endtask

    task automatic test_extremes();
        vec_t v;
        int lat, e_idx; longint e_max, e_mg;
        for (int i = 0; i < N; i++) v[i] = 32'sh8000_0000;
        v[9] = 32'sh7FFF_FFFF;
        model(v, e_idx, e_max, e_mg);
        launch(v, lat);
        n_checks++; if (class_index !== IW'(e_idx)) $display("FAIL extreme_index: got %0d expected %0d", class_index, e_idx); else n_pass++;
        n_checks++; if (max_value !== DW'(e_max)) $display("FAIL extreme_value: got %h expected %h", max_value, DW'(e_max)); else n_pass++;
        n_checks++; if (margin !== (DW+1)'(e_mg)) $display("FAIL extreme_margin: got %h expected %h", margin, (DW+1)'(e_mg)); else n_pass++;
    endtask

    // Random vectors, half drawn from a tiny range so ties are common, with a
    // random idle gap (0 = back-to-back launch in the outputs_ready cycle).
    task automatic test_random();
        vec_t v;
        int lat, e_idx, tmp; longint e_max, e_mg;
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < N; i++) begin
                tmp = (t % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 8)) - 4;
                v[i] = tmp;
            end
            model(v, e_idx, e_max, e_mg);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            launch(v, lat);
            n_checks++; if (lat !== 10) $display("FAIL random_latency[%0d]: got %0d expected 10", t, lat); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL random_busy_at_ready[%0d]: got %b expected 0", t, busy); else n_pass++;
            n_checks++; if (class_index !== IW'(e_idx)) $display("FAIL random_index[%0d]: got %0d expected %0d", t, class_index, e_idx); else n_pass++;
            n_checks++; if (max_value !== DW'(e_max)) $display("FAIL random_value[%0d]: got %0d expected %0d", t, $signed(max_value), e_max); else n_pass++;
            n_checks++; if (margin !== (DW+1)'(e_mg)) $display("FAIL random_margin[%0d]: got %0d expected %0d", t, margin, e_mg); else n_pass++;
        end
    endtask

    task automatic test_overrun();
        vec_t v1 = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
        vec_t v2 = '{900, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        vec_t v3 = '{-1, -1, -1, -1, -1, -1, -1, 12, -1, -1};
        int lat, e_idx; longint e_max, e_mg;
        @(negedge clock);
        n_checks++; if (overrun !== 1'b0) $display("FAIL overrun_initial: got %b expected 0", overrun); else n_pass++;
        model(v1, e_idx, e_max, e_mg);
        for (int i = 0; i < N; i++) inputs[i] = v1[i];
        inputs_ready = 1'b1;
        @(negedge clock);
        inputs_ready = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (lat < 0) begin
                @(negedge clock);
                if (k == 3) begin
                    for (int i = 0; i < N; i++) inputs[i] = v2[i];
                    inputs_ready = 1'b1;    // sampled at E4 while busy
                end else begin
                    inputs_ready = 1'b0;
                end
                if (outputs_ready) lat = k;
            end
        end
        n_checks++; if (lat !== 10) $display("FAIL overrun_first_latency: got %0d expected 10", lat); else n_pass++;
        n_checks++; if (class_index !== IW'(e_idx)) $display("FAIL overrun_first_index: got %0d expected %0d", class_index, e_idx); else n_pass++;
        n_checks++; if (max_value !== DW'(e_max)) $display("FAIL overrun_first_value: got %0d expected %0d", $signed(max_value), e_max); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun); else n_pass++;
        model(v3, e_idx, e_max, e_mg);
        launch(v3, lat);    // sampled at E11, due at E21
        n_checks++; if (lat !== 10) $display("FAIL overrun_third_latency: got %0d expected 10", lat); else n_pass++;
        n_checks++; if (class_index !== IW'(e_idx)) $display("FAIL overrun_third_index: got %0d expected %0d", class_index, e_idx); else n_pass++;
        n_checks++; if (max_value !== DW'(e_max)) $display("FAIL overrun_third_value: got %0d expected %0d", $signed(max_value), e_max); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_still_set: got %b expected 1", overrun); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        vec_t v  = '{5, 4, 3, 2, 1, 0, 77, 2, 3, 4};
        vec_t v2 = '{-3, 8, 8, 1, 0, 0, 0, 0, 0, -100};
        int lat, e_idx, seen; longint e_max, e_mg;
        for (int i = 0; i < N; i++) inputs[i] = v[i];
        inputs_ready = 1'b1;
        @(negedge clock);
        inputs_ready = 1'b0;
        repeat (5) @(negedge clock);    // between E5 and E6
        reset = 1'b0;
        #1;
        n_checks++; if ({class_index, max_value, margin} !== '0) $display("FAIL midreset_outputs: got %h expected 0", {class_index, max_value, margin}); else n_pass++;
        n_checks++; if ({outputs_ready, busy, overrun} !== 3'b000) $display("FAIL midreset_flags: got %b expected 000", {outputs_ready, busy, overrun}); else n_pass++;
        #2;
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (outputs_ready) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL midreset_no_ready: got %0d pulses expected 0", seen); else n_pass++;
        model(v2, e_idx, e_max, e_mg);
        launch(v2, lat);
        n_checks++; if (lat !== 10) $display("FAIL midreset_new_latency: got %0d expected 10", lat); else n_pass++;
        n_checks++; if (class_index !== IW'(e_idx)) $display("FAIL midreset_new_index: got %0d expected %0d", class_index, e_idx); else n_pass++;
        n_checks++; if (margin !== (DW+1)'(e_mg)) $display("FAIL midreset_new_margin: got %0d expected %0d", margin, e_mg); else n_pass++;
    endtask

    task automatic test_single();
        s_inputs[0] = -32'sd42;
        s_inputs_ready = 1'b1;
        @(negedge clock);
        s_inputs_ready = 1'b0;
        n_checks++; if ({s_outputs_ready, s_busy} !== 2'b01) $display("FAIL single_after_e0: got %b expected 01", {s_outputs_ready, s_busy}); else n_pass++;
        @(negedge clock);
        n_checks++; if (s_outputs_ready !== 1'b1) $display("FAIL single_ready_e1: got %b expected 1", s_outputs_ready); else n_pass++;
        n_checks++; if (s_class_index !== 1'b0) $display("FAIL single_index: got %0d expected 0", s_class_index); else n_pass++;
        n_checks++; if (s_max_value !== 32'hFFFF_FFD6) $display("FAIL single_value: got %0d expected -42", $signed(s_max_value)); else n_pass++;
        n_checks++; if (s_margin !== '0) $display("FAIL single_margin: got %0d expected 0", s_margin); else n_pass++;
        @(negedge clock);
        n_checks++; if (s_outputs_ready !== 1'b0) $display("FAIL single_pulse_width: got %b expected 0", s_outputs_ready); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_distinct();
        test_negative_tie();
        test_extremes();
        test_random();
        test_overrun();
        test_reset_mid_scan();
        test_single();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/argmax_classifier.md
# argmax_classifier

Output stage that consumes the final dense-layer result vector and reduces it to a predicted class. It registers the signed output vector on the `inputs_ready` pulse, then scans it one element per cycle. When the scan finishes it presents the index and value of the maximum, and pulses `outputs_ready`. It sits directly downstream of the network's output layer: its `inputs`/`inputs_ready` connect to that layer's `outputs`/`outputs_ready`.

## Interface
- `DATA_WIDTH`, 32: width of each signed element.
- `NUM_INPUTS`, 10: vector length (number of classes), ≥1.
- `INDEX_WIDTH`, `$clog2(NUM_INPUTS)` (minimum 1): width of the class index.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inputs_ready`  in  1  one-cycle pulse: `inputs` valid this cycle.
- `inputs`  in  `[DATA_WIDTH-1:0] signed x NUM_INPUTS`  score vector.
- `class_index`  out  `INDEX_WIDTH`  index of the maximum element.
- `max_value`  out  `DATA_WIDTH` signed  value of the maximum element.
- `margin`  out  `DATA_WIDTH+1` unsigned  max minus second-highest (see Configuration).
- `outputs_ready`  out  1  one-cycle pulse: results updated.
- `busy`  out  1  high while not IDLE.
- `overrun`  out  1  sticky: an `inputs_ready` pulse arrived while busy.

## Operation
- FSM states: IDLE, SCAN, PUBLISH.
- **IDLE**
  - On `inputs_ready`: capture all `inputs` into an internal buffer.
  - Seed the working max with element 0, working index 0, counter = 1.
  - Go to SCAN, or to PUBLISH if `NUM_INPUTS`==1.
- **SCAN**
  - Each cycle, compare buffer[counter] against the working max using a signed compare.
  - Replace working max/index only if the element is strictly greater. Ties therefore keep the lowest index.
  - Increment counter. After element `NUM_INPUTS-1` is compared, go to PUBLISH.
- **PUBLISH**
  - Copy working max/index (and margin) into the output registers.
  - Assert `outputs_ready` and return to IDLE.
- Output registers hold their value until the next PUBLISH.
- `busy` = (state != IDLE).
- `inputs_ready` while busy:
  - The pulse is dropped; the buffer is not disturbed.
  - `overrun` is set and stays set until reset.
- Reset (`reset`=0, any time, including mid-scan):
  - State → IDLE.
  - `class_index`, `max_value`, `margin`, `outputs_ready`, `overrun`, counter and buffer → 0.
  - `busy` → 0.
- Arithmetic: comparisons use full-width signed values. No truncation anywhere except in `margin`, which is defined under Configuration.

## Timing
- E0 is the rising edge that samples `inputs_ready`=1 in IDLE.
- Elements 1..N-1 are compared at edges E1..E(N-1).
- At edge E(N): results update and `outputs_ready` goes high for exactly one cycle.
- Latency: `NUM_INPUTS` cycles from the sampling edge to `outputs_ready`. Default is 10; N=1 gives 1.
- Back-to-back: a new `inputs_ready` is accepted at edge E(N+1), i.e. during the `outputs_ready` cycle. Minimum period is N+1 cycles.
- The pulse is ignored at edges E1..E(N), when `busy`=1.

## Configuration
- `ARGMAX_MARGIN_EN`, defined:
  - SCAN also tracks the second-highest value. The second-highest is seeded to the most negative value, and it is updated on demotion of the max or on a strictly-between element.
  - `margin` = max − second, as an unsigned `DATA_WIDTH+1` value.
  - With N=1, `margin` = 0.
  - Equal top values give `margin` = 0.
- Not defined: the second-highest logic is absent and `margin` is driven constant 0. Port list and latency are unchanged.

## Structure
- Shared package holds the FSM state enum (`argmax_state_t`) and a function computing `INDEX_WIDTH` with a minimum of 1. The package is shared with the existing layer `ACTIVATION`/`LAYER` types.
- A single module is enough; no sub-module.
- The compare/update step can be a package function so it is reusable by a future top-k block.

## Test plan
- **Distinct maximum.** N=10, inputs {3,-5,7,100,2,0,-1,99,4,6}, pulse at E0.
  - `outputs_ready` at E10 with `class_index`=3 and `max_value`=100.
  - With the macro: `margin`=1.
- **All negative, with tie.** Inputs {-8,-2,-9,-2,-30,-5,-7,-4,-3,-6}.
  - `class_index`=1, `max_value`=-2, `margin`=0 (macro).
- **Extreme values.**
  - Element 9 = 0x7FFFFFFF, all others 0x80000000: `class_index`=9.
  - With the macro: `margin`=0xFFFFFFFF (33-bit).
- **Overrun.** Second `inputs_ready` at E4.
  - Ignored: the first result is still published at E10 and `overrun`=1.
  - A third pulse at E11 is accepted; its result appears at E21.
- **Reset mid-scan.** `reset` low between E5 and E6.
  - All outputs go 0 asynchronously and there is no `outputs_ready`.
  - After release, a new vector completes normally in 10 cycles.
- **N=1 build.** Input {-42}: `outputs_ready` at E1 with `class_index`=0 and `max_value`=-42.
